instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0040_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 imem_req  output  1  SHALL request an instruction read from memory.
REQ-005 imem_addr  output  32  SHALL carry the byte address of the requested instruction.
REQ-006 imem_ack  input  1  SHALL mark imem_rdata valid for the outstanding request.
REQ-007 imem_rdata  input  32  SHALL carry the instruction word returned by memory.
REQ-008 instruction  output  32  SHALL carry the registered instruction for the decode/execute stage.
REQ-009 pc_out  output  32  SHALL carry the address of the instruction currently presented.
REQ-010 instr_valid  output  1  SHALL mark instruction and pc_out valid.
REQ-011 instr_ready  input  1  SHALL mark that the consumer accepts the presented instruction this cycle.
REQ-012 branch_taken  input  1  SHALL mark a taken conditional branch (Branch AND Zero) for the accepted instruction.
REQ-013 branch_offset  input  32  SHALL carry the sign-extended 16-bit immediate of the accepted instruction.
REQ-014 jump  input  1  SHALL mark the accepted instruction as an unconditional jump.
REQ-015 jump_target  input  26  SHALL carry the 26-bit jump index field of the accepted instruction.

Function
REQ-016 FSM SHALL have states IDLE, REQ, VALID; encoding is free.
REQ-017 IDLE: imem_req=0, instr_valid=0; SHALL go to REQ on the first clock edge after rst_n deasserts.
REQ-018 REQ: imem_req=1, imem_addr=pc; on imem_ack=1 SHALL latch imem_rdata into instruction, latch pc into pc_out, and go to VALID.
REQ-019 Zero-wait memory (imem_ack high in the first REQ cycle) SHALL be supported; minimum latency is one cycle from the imem_req rise to instr_valid=1.
REQ-020 imem_addr SHALL stay stable while imem_req=1; imem_ack while imem_req=0 SHALL be ignored.
REQ-021 VALID: instr_valid=1, imem_req=0; instruction and pc_out SHALL hold while instr_ready=0.
REQ-022 VALID with instr_ready=1: pc SHALL load next_pc, and the state SHALL go to REQ.
REQ-023 pc_plus4 = pc_out + 4, computed modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-024 Branch target SHALL equal pc_plus4 + (branch_offset << 2), computed modulo 2^32.
REQ-025 Jump target SHALL equal {pc_plus4[31:28], jump_target, 2'b00}.
REQ-026 next_pc priority SHALL be jump > branch_taken > pc_plus4.
REQ-027 branch_taken, branch_offset, jump and jump_target SHALL be sampled only in the cycle where instr_valid=1 and instr_ready=1; they are ignored otherwise.
REQ-028 A handshake cycle SHALL produce no bubble beyond the single REQ state; throughput is at most one instruction per two cycles.

Reset
REQ-029 On rst_n=0 the block SHALL immediately enter IDLE, with pc=RESET_PC, pc_out=RESET_PC, instruction=0, imem_req=0, instr_valid=0.
REQ-030 Reset asserted mid-request SHALL abandon the request; a late imem_ack after reset release and before re-entry to REQ SHALL be ignored.
REQ-031 After release, the first request SHALL be to RESET_PC.

Verification
REQ-032 Reset release, zero-wait memory returning 32'h2009_0005, instr_ready=1 -> imem_addr=32'h0040_0000; instruction=32'h2009_0005 and pc_out=32'h0040_0000 with instr_valid=1; next imem_addr=32'h0040_0004.
REQ-033 Memory acks after 3 wait cycles, instr_ready held 0 for 4 cycles in VALID -> imem_addr stable during REQ; instruction/pc_out stable and imem_req=0 throughout the stall.
REQ-034 pc_out=32'h0040_0010, branch_taken=1, branch_offset=32'hFFFF_FFFE -> next imem_addr=32'h0040_000C.
REQ-035 pc_out=32'h0040_0010, jump=1, jump_target=26'h010_0008, branch_taken=1 -> next imem_addr=32'h0040_0020 (jump wins).
REQ-036 RESET_PC=32'hFFFF_FFFC, sequential fetch -> second imem_addr=32'h0000_0000.
REQ-037 rst_n pulsed low during REQ with imem_ack arriving one cycle after release -> ack ignored, instr_valid stays 0, next request is to RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory request/ack channel plus the
// valid/ready handoff (with branch/jump redirect) toward decode.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;

    modport master (
        output imem_req, imem_addr, instruction, pc_out, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset, jump, jump_target
    );

    modport slave (
        input  imem_req, imem_addr, instruction, pc_out, instr_valid,
        output imem_ack, imem_rdata, instr_ready, branch_taken, branch_offset, jump, jump_target
    );
endinterface

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch unit: requests the word at pc, registers it for
// decode, and computes the next pc (jump > taken branch > sequential) on handoff.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input logic                 clk,
    input logic                 rst_n,
    instruction_fetch_if.master bus
);
    typedef enum logic [1:0] {StIdle, StReq, StValid} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_plus4, branch_pc, jump_pc, next_pc;

    always_comb begin
        pc_plus4  = pc_out_q + 32'd4;
        branch_pc = pc_plus4 + (bus.branch_offset << 2);
        jump_pc   = {pc_plus4[31:28], bus.jump_target, 2'b00};
        if (bus.jump) begin
            next_pc = jump_pc;
        end else if (bus.branch_taken) begin
            next_pc = branch_pc;
        end else begin
            next_pc = pc_plus4;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pc_out_d        = pc_out_q;
        instr_d         = instr_q;
        bus.imem_req    = 1'b0;
        bus.instr_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StReq;
            end
            StReq: begin
                bus.imem_req = 1'b1;
                if (bus.imem_ack) begin
                    instr_d  = bus.imem_rdata;
                    pc_out_d = pc_q;
                    state_d  = StValid;
                end
            end
            StValid: begin
                bus.instr_valid = 1'b1;
                // Redirect inputs only matter on the handoff cycle itself.
                if (bus.instr_ready) begin
                    pc_d    = next_pc;
                    state_d = StReq;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            pc_q     <= RESET_PC;
            pc_out_q <= RESET_PC;
            instr_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            pc_out_q <= pc_out_d;
            instr_q  <= instr_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.instruction = instr_q;
    assign bus.pc_out      = pc_out_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: cycle-level reference model plus literal pins,
// and a second instance with RESET_PC at the top of the address space.
module tb_instruction_fetch;
    localparam logic [31:0] ARst = 32'h0040_0000;
    localparam logic [31:0] BRst = 32'hFFFF_FFFC;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    instruction_fetch_if a_bus ();
    instruction_fetch_if b_bus ();

    instruction_fetch #(.RESET_PC(ARst)) u_a (.clk(clk), .rst_n(rst_n), .bus(a_bus));
    instruction_fetch #(.RESET_PC(BRst)) u_b (.clk(clk), .rst_n(rst_n), .bus(b_bus));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2009_0005;
        return (a ^ 32'h5A5A_1234) + 32'd1;
    endfunction

    // Next fetch address straight from the redirect rules, on plain integers.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic br,
                                               input logic [31:0] off, input logic jp,
                                               input logic [25:0] jt);
        logic [31:0] p4;
        p4 = pc + 32'd4;
        if (jp) return {p4[31:28], jt, 2'b00};
        if (br) return p4 + off * 32'd4;
        return p4;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // B: always-ready consumer, zero-wait memory, straight-line code.
    assign b_bus.imem_ack      = b_bus.imem_req;
    assign b_bus.imem_rdata    = mem_word(b_bus.imem_addr);
    assign b_bus.instr_ready   = 1'b1;
    assign b_bus.branch_taken  = 1'b0;
    assign b_bus.branch_offset = 32'd0;
    assign b_bus.jump          = 1'b0;
    assign b_bus.jump_target   = 26'd0;

    logic [31:0] b_addrs [2];
    int          b_n;

    // Reference model of A: phase 0 idle, 1 requesting, 2 presenting.
    int          m_phase;
    logic [31:0] m_pc, m_out, m_instr;

    initial begin
        b_n = 0;
        m_phase = 0;
        m_pc = ARst;
        m_out = ARst;
        m_instr = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = 0;
                m_pc    = ARst;
                m_out   = ARst;
                m_instr = 32'd0;
            end
            chk("imem_req", {31'd0, a_bus.imem_req}, {31'd0, m_phase == 1});
            chk("instr_valid", {31'd0, a_bus.instr_valid}, {31'd0, m_phase == 2});
            if (m_phase == 1) chk("imem_addr", a_bus.imem_addr, m_pc);
            chk("instruction", a_bus.instruction, m_instr);
            chk("pc_out", a_bus.pc_out, m_out);
            if (rst_n) begin
                if (m_phase == 0) begin
                    m_phase = 1;
                end else if (m_phase == 1) begin
                    if (a_bus.imem_ack) begin
                        m_instr = mem_word(m_pc);
                        m_out   = m_pc;
                        m_phase = 2;
                    end
                end else if (a_bus.instr_ready) begin
                    m_pc    = model_next(m_out, a_bus.branch_taken, a_bus.branch_offset,
                                         a_bus.jump, a_bus.jump_target);
                    m_phase = 1;
                end
                if (b_bus.imem_req && b_n < 2) begin
                    b_addrs[b_n] = b_bus.imem_addr;
                    b_n++;
                end
            end
        end
    end

    task automatic junk();
        a_bus.branch_taken  = 1'b1;
        a_bus.jump          = 1'b1;
        a_bus.branch_offset = $urandom;
        a_bus.jump_target   = 26'($urandom);
    endtask

    // One transaction: wt ack wait cycles, st stall cycles, then handoff with redirect.
    task automatic fetch(input int wt, input int st, input logic br, input logic [31:0] off,
                         input logic jp, input logic [25:0] jt,
                         output logic [31:0] seen_i, output logic [31:0] seen_pc);
        int n;
        n = 0;
        while (!a_bus.imem_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!a_bus.imem_req) timeout("req_wait");
        repeat (wt) begin
            a_bus.imem_ack    = 1'b0;
            a_bus.instr_ready = 1'b1;
            junk();
            @(posedge clk); #1;
        end
        a_bus.instr_ready = 1'b0;
        a_bus.imem_ack    = 1'b1;
        a_bus.imem_rdata  = mem_word(a_bus.imem_addr);
        @(posedge clk); #1;
        a_bus.imem_ack   = 1'b0;
        a_bus.imem_rdata = 32'hDEAD_BEEF;
        n = 0;
        while (!a_bus.instr_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!a_bus.instr_valid) timeout("valid_wait");
        seen_i  = a_bus.instruction;
        seen_pc = a_bus.pc_out;
        repeat (st) begin
            a_bus.instr_ready = 1'b0;
            junk();
            a_bus.imem_ack = 1'b1;
            @(posedge clk); #1;
        end
        a_bus.imem_ack      = 1'b0;
        a_bus.instr_ready   = 1'b1;
        a_bus.branch_taken  = br;
        a_bus.branch_offset = off;
        a_bus.jump          = jp;
        a_bus.jump_target   = jt;
        @(posedge clk); #1;
        a_bus.instr_ready = 1'b0;
        junk();
    endtask

    logic [31:0] si, sp;

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        a_bus.imem_ack = 1'b0;
        a_bus.imem_rdata = 32'd0;
        a_bus.instr_ready = 1'b0;
        a_bus.branch_taken = 1'b0;
        a_bus.branch_offset = 32'd0;
        a_bus.jump = 1'b0;
        a_bus.jump_target = 26'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pc_out", a_bus.pc_out, 32'h0040_0000);
        chk("rst_instr", a_bus.instruction, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_addr", a_bus.imem_addr, 32'h0040_0000);

        fetch(0, 0, 1'b0, 32'd0, 1'b0, 26'd0, si, sp);
        chk("t1_instr", si, 32'h2009_0005);
        chk("t1_pc", sp, 32'h0040_0000);
        chk("t1_next", a_bus.imem_addr, 32'h0040_0004);

        fetch(3, 4, 1'b0, 32'd0, 1'b0, 26'd0, si, sp);
        chk("t2_pc", sp, 32'h0040_0004);
        fetch(0, 0, 1'b0, 32'd0, 1'b0, 26'd0, si, sp);
        fetch(1, 1, 1'b0, 32'd0, 1'b0, 26'd0, si, sp);
        fetch(0, 0, 1'b1, 32'hFFFF_FFFE, 1'b0, 26'd0, si, sp);
        chk("t5_pc", sp, 32'h0040_0010);
        chk("branch_back", a_bus.imem_addr, 32'h0040_000C);
        fetch(0, 0, 1'b0, 32'd0, 1'b0, 26'd0, si, sp);
        fetch(2, 0, 1'b1, 32'h0000_0005, 1'b1, 26'h010_0008, si, sp);
        chk("t7_pc", sp, 32'h0040_0010);
        chk("jump_wins", a_bus.imem_addr, 32'h0040_0020);
        fetch(0, 2, 1'b1, 32'h0000_0010, 1'b0, 26'd0, si, sp);
        chk("branch_fwd", a_bus.imem_addr, 32'h0040_0064);
        fetch(0, 0, 1'b0, 32'd0, 1'b1, 26'h3FF_FFFF, si, sp);
        chk("jump_far", a_bus.imem_addr, 32'h0FFF_FFFC);
        fetch(1, 0, 1'b0, 32'd0, 1'b0, 26'd0, si, sp);
        chk("seq_cross", a_bus.imem_addr, 32'h1000_0000);
        fetch(0, 0, 1'b0, 32'd0, 1'b1, 26'h000_0001, si, sp);
        chk("jump_region", a_bus.imem_addr, 32'h1000_0004);

        // Abandon the request mid-flight; a late ack must not be taken.
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_req", {31'd0, a_bus.imem_req}, 32'd0);
        chk("mid_rst_pc_out", a_bus.pc_out, 32'h0040_0000);
        rst_n = 1'b1;
        a_bus.imem_ack = 1'b1;
        a_bus.imem_rdata = 32'hBAD0_0BAD;
        @(posedge clk); #1;
        a_bus.imem_ack = 1'b0;
        chk("late_ack_valid", {31'd0, a_bus.instr_valid}, 32'd0);
        chk("late_ack_addr", a_bus.imem_addr, 32'h0040_0000);
        fetch(1, 2, 1'b0, 32'd0, 1'b0, 26'd0, si, sp);
        chk("post_rst_instr", si, 32'h2009_0005);
        fetch(0, 0, 1'b0, 32'd0, 1'b0, 26'd0, si, sp);
        repeat (2) @(posedge clk);
        #1;

        if (b_n < 2) begin
            timeout("b_capture");
        end else begin
            chk("b_first_addr", b_addrs[0], 32'hFFFF_FFFC);
            chk("b_wrap_addr", b_addrs[1], 32'h0000_0000);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
